// File: rtl/load_store_unit.sv
// load_store_unit: decodes, aligns and sequences one memory load or store at a time
module load_store_unit #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Load,
  input  logic [2:0]  Store,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        misaligned_err,
  output logic        timeout_err
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_wstrb;
  logic [4:0]  r_ltype;
  logic [1:0]  r_lane;
  logic        r_we, r_mis, r_to;
  logic [7:0]  w_sel;
  logic        w_valid, w_mis, w_go, w_timeout;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_shift, w_load;
  logic [15:0] w_half;
  assign w_sel     = {Store, Load};
  assign w_valid   = (w_sel != 8'd0) && ((w_sel & (w_sel - 8'd1)) == 8'd0);
  assign w_mis     = ((Load[1] | Load[4] | Store[1]) & ALUResult[0]) |
                     ((Load[2] | Store[2]) & (ALUResult[1:0] != 2'b00));
  assign w_go      = (r_state == IDLE) && w_valid && !w_mis;
  assign w_timeout = (r_state == REQ) && !mem_ready && (r_cnt == CW'(MAX_WAIT - 1));
  assign w_wstrb   = Store[0] ? (4'b0001 << ALUResult[1:0]) :
                     Store[1] ? (ALUResult[1] ? 4'b1100 : 4'b0011) :
                     Store[2] ? 4'b1111 : 4'b0000;
  assign w_wdata   = Store[0] ? {4{WriteData[7:0]}} :
                     Store[1] ? {2{WriteData[15:0]}} :
                     Store[2] ? WriteData : 32'd0;
  assign w_shift   = mem_rdata >> {r_lane, 3'b000};
  assign w_half    = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign w_load    = r_ltype[0] ? {{24{w_shift[7]}}, w_shift[7:0]} :
                     r_ltype[1] ? {{16{w_half[15]}}, w_half} :
                     r_ltype[3] ? {24'd0, w_shift[7:0]} :
                     r_ltype[4] ? {16'd0, w_half} : mem_rdata;
  assign mem_we         = r_we;
  assign mem_addr       = r_addr;
  assign mem_wdata      = r_wdata;
  assign mem_wstrb      = r_wstrb;
  assign ReadData       = r_rdata;
  assign misaligned_err = r_mis;
  assign timeout_err    = r_to;
  // next state plus request/stall: stall starts combinationally on the accepting IDLE cycle
  always_comb begin
    w_next  = r_state;
    mem_req = 1'b0;
    Stall   = 1'b0;
    if (r_state == IDLE) begin
      w_next = w_go ? REQ : IDLE;
      Stall  = w_go;
    end else if (r_state == REQ) begin
      w_next  = (mem_ready || w_timeout) ? DONE : REQ;
      mem_req = 1'b1;
      Stall   = 1'b1;
    end else begin
      w_next = IDLE;
    end
  end
  // state, captured access, wait counter, load result and sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_we    <= 1'b0;
      r_ltype <= '0;
      r_lane  <= '0;
      r_rdata <= '0;
      r_mis   <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_addr  <= {ALUResult[31:2], 2'b00};
        r_we    <= |Store;
        r_wdata <= w_wdata;
        r_wstrb <= w_wstrb;
        r_ltype <= Load;
        r_lane  <= ALUResult[1:0];
        r_cnt   <= '0;
      end
      if (r_state == REQ && !mem_ready) r_cnt <= r_cnt + CW'(1);
      if (r_state == REQ && mem_ready && r_ltype != 5'd0) r_rdata <= w_load;
      if (w_timeout) begin
        r_rdata <= '0;
        r_to    <= 1'b1;
      end
      if (r_state == IDLE && w_valid && w_mis) r_mis <= 1'b1;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus hand sequences for error, timeout and reset cases
module tb_load_store_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic [4:0]  Load = '0;
  logic [2:0]  Store = '0;
  logic [31:0] ALUResult = '0, WriteData = '0, mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, Stall, misaligned_err, timeout_err;
  logic [31:0] mem_addr, mem_wdata, ReadData;
  logic [3:0]  mem_wstrb;
  int total = 0, bad = 0;
  load_store_unit #(.MAX_WAIT(16)) dut (
    .clk(clk), .rst(rst), .Load(Load), .Store(Store), .ALUResult(ALUResult),
    .WriteData(WriteData), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .ReadData(ReadData), .Stall(Stall),
    .misaligned_err(misaligned_err), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0]  ld;
    logic [2:0]  st;
    logic [31:0] addr, wd, rd, eaddr;
    logic [3:0]  estrb;
    logic [31:0] ewdata, erdata;
  } vec_t;
  vec_t tv[10];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  task automatic idle_inputs();
    Load = '0; Store = '0; ALUResult = '0; WriteData = '0;
  endtask
  initial begin
    tv[0] = '{5'b00001, 3'b000, 32'h1003, 32'h0, 32'h80AABBCC, 32'h1000, 4'h0, 32'h0, 32'hFFFFFF80};
    tv[1] = '{5'b10000, 3'b000, 32'h2002, 32'h0, 32'h8001FFFF, 32'h2000, 4'h0, 32'h0, 32'h00008001};
    tv[2] = '{5'b00010, 3'b000, 32'h2002, 32'h0, 32'h8001FFFF, 32'h2000, 4'h0, 32'h0, 32'hFFFF8001};
    tv[3] = '{5'b01000, 3'b000, 32'h0001, 32'h0, 32'h0000F500, 32'h0000, 4'h0, 32'h0, 32'h000000F5};
    tv[4] = '{5'b00100, 3'b000, 32'h0100, 32'h0, 32'hDEADBEEF, 32'h0100, 4'h0, 32'h0, 32'hDEADBEEF};
    tv[5] = '{5'b00010, 3'b000, 32'h0000, 32'h0, 32'h12347FFE, 32'h0000, 4'h0, 32'h0, 32'h00007FFE};
    tv[6] = '{5'b00000, 3'b001, 32'h0005, 32'h123456AB, 32'h0, 32'h0004, 4'b0010, 32'hABABABAB, 32'h00007FFE};
    tv[7] = '{5'b00000, 3'b010, 32'h000A, 32'hAAAA1234, 32'h0, 32'h0008, 4'b1100, 32'h12341234, 32'h00007FFE};
    tv[8] = '{5'b00000, 3'b100, 32'h0010, 32'hCAFEF00D, 32'h0, 32'h0010, 4'b1111, 32'hCAFEF00D, 32'h00007FFE};
    tv[9] = '{5'b00001, 3'b000, 32'h0000, 32'h0, 32'h0000007F, 32'h0000, 4'h0, 32'h0, 32'h0000007F};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_rdata", ReadData, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_errs", {30'd0, misaligned_err, timeout_err}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      Load = tv[i].ld; Store = tv[i].st; ALUResult = tv[i].addr; WriteData = tv[i].wd;
      #1;
      chk($sformatf("v%0d_stall_idle", i), {31'd0, Stall}, 32'd1);
      chk($sformatf("v%0d_req_idle", i), {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      Load = 5'b00100; Store = '0; ALUResult = 32'hFFFF_FFF0; WriteData = 32'h5555_5555;
      mem_ready = 1'b1; mem_rdata = tv[i].rd;
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, mem_req}, 32'd1);
      chk($sformatf("v%0d_stall_req", i), {31'd0, Stall}, 32'd1);
      chk($sformatf("v%0d_addr", i), mem_addr, tv[i].eaddr);
      chk($sformatf("v%0d_we", i), {31'd0, mem_we}, {31'd0, |tv[i].st});
      if (tv[i].st != 3'd0) begin
        chk($sformatf("v%0d_wstrb", i), {28'd0, mem_wstrb}, {28'd0, tv[i].estrb});
        chk($sformatf("v%0d_wdata", i), mem_wdata, tv[i].ewdata);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk($sformatf("v%0d_done_req", i), {31'd0, mem_req}, 32'd0);
      chk($sformatf("v%0d_done_stall", i), {31'd0, Stall}, 32'd0);
      chk($sformatf("v%0d_rdata", i), ReadData, tv[i].erdata);
      idle_inputs();
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_back_idle", i), {31'd0, mem_req}, 32'd0);
      chk($sformatf("v%0d_no_mis", i), {31'd0, misaligned_err}, 32'd0);
    end
    Load = 5'b00011; ALUResult = 32'h40;
    #1;
    chk("multi_stall", {31'd0, Stall}, 32'd0);
    @(negedge clk);
    #1;
    chk("multi_req", {31'd0, mem_req}, 32'd0);
    chk("multi_no_mis", {31'd0, misaligned_err}, 32'd0);
    Load = '0; Store = 3'b100; ALUResult = 32'h6; WriteData = 32'h1;
    #1;
    chk("mis_stall", {31'd0, Stall}, 32'd0);
    chk("mis_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("mis_set", {31'd0, misaligned_err}, 32'd1);
    chk("mis_no_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    #1;
    chk("mis_sticky", {31'd0, misaligned_err}, 32'd1);
    Load = 5'b00100; ALUResult = 32'h40;
    @(negedge clk);
    idle_inputs();
    begin
      int n = 0;
      #1;
      while (mem_req && n < 40) begin
        n++;
        @(negedge clk);
        #1;
      end
      chk("to_req_cycles", n, 32'd16);
    end
    chk("to_rdata", ReadData, 32'd0);
    chk("to_err", {31'd0, timeout_err}, 32'd1);
    chk("to_stall", {31'd0, Stall}, 32'd0);
    @(negedge clk);
    Load = 5'b00100; ALUResult = 32'h80;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_mid_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst2_req", {31'd0, mem_req}, 32'd0);
    chk("rst2_stall", {31'd0, Stall}, 32'd0);
    chk("rst2_errs", {30'd0, misaligned_err, timeout_err}, 32'd0);
    chk("rst2_addr", mem_addr, 32'd0);
    @(negedge clk);
    #1;
    chk("rst2_stay_idle", {31'd0, mem_req}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
